// File: rtl/mdu_if.sv
// mdu_if -- request/response bundle between the issue stage and mdu_riscv.
//   master : issue side; drives start_i, op_i, rd_addr_i, rs1_i, rs2_i, flush_i
//            and observes busy_o, valid_o, rd_addr_o, result_o.
//   slave  : the multiply/divide unit; the opposite directions.
// Signal names keep the unit's port names so the suffix still reads as seen
// from the MDU.
interface mdu_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        valid_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] result_o;

    modport master (
        output start_i, op_i, rd_addr_i, rs1_i, rs2_i, flush_i,
        input  busy_o, valid_o, rd_addr_o, result_o
    );

    modport slave (
        input  start_i, op_i, rd_addr_i, rs1_i, rs2_i, flush_i,
        output busy_o, valid_o, rd_addr_o, result_o
    );
endinterface

// File: rtl/mdu_riscv.sv
// mdu_riscv -- iterative RV32M multiply/divide unit.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : mdu_if.slave (start/op/rd/rs1/rs2/flush in; busy/valid/rd/result out)
// Multiplies: radix-2 shift-add, 32 iterations. Divides: restoring, 32
// iterations. Divide-by-zero and signed overflow finish at capture.
// Build option: MDU_FAST_MUL_EN -- single-cycle multiply, IDLE -> DONE.
module mdu_riscv (
    input  logic clk_i,
    input  logic rst_i,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, lo_q, opb_q;    // {hi,lo}: product / {remainder,quotient}
    logic [4:0]  cnt_q, rd_q, rd_out_q;
    logic [1:0]  op_q;
    logic        neg_q;
    logic [31:0] result_q;

    // ---------------- capture-side decode ----------------
    logic        accept, a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, special_res;
    logic        div_zero, div_ovf, special;

    assign accept   = bus.start_i && !bus.flush_i && (state_q == S_IDLE);
    // MULH, MULHSU, DIV, REM read A as signed; MULH, DIV, REM read B as signed.
    assign a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                      (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    assign b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) ||
                      (bus.op_i == 3'b110);
    assign a_neg    = a_signed && bus.rs1_i[31];
    assign b_neg    = b_signed && bus.rs2_i[31];
    assign a_mag    = a_neg ? -bus.rs1_i : bus.rs1_i;
    assign b_mag    = b_neg ? -bus.rs2_i : bus.rs2_i;

    assign div_zero = bus.op_i[2] && (bus.rs2_i == 32'h0);
    assign div_ovf  = bus.op_i[2] && !bus.op_i[0] &&
                      (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;
    // op_i[1] separates REM/REMU from DIV/DIVU.
    assign special_res = div_zero ? (bus.op_i[1] ? bus.rs1_i : 32'hFFFF_FFFF)
                                  : (bus.op_i[1] ? 32'h0 : 32'h8000_0000);

`ifdef MDU_FAST_MUL_EN
    // 33-bit signed operands (sign bit only for signed ops) widened to 64 bits;
    // the low 64 bits of the product are exact.
    logic signed [63:0] fa, fb, fprod;
    logic [31:0]        fast_res;
    assign fa       = {{32{a_neg}}, bus.rs1_i};
    assign fb       = {{32{b_neg}}, bus.rs2_i};
    assign fprod    = fa * fb;
    assign fast_res = (bus.op_i[1:0] == 2'b00) ? fprod[31:0] : fprod[63:32];
`endif

    // ---------------- one iteration ----------------
    logic [32:0] mul_sum, rem_sh;
    logic [31:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, neg_hi, iter_res;
    logic        ge;

    // Shift-add: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole 65-bit {carry,hi,lo} right by one.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'h0);
    assign mul_hi_n = mul_sum[32:1];
    assign mul_lo_n = {mul_sum[0], lo_q[31:1]};

    // Restoring divide: shift next dividend bit into the remainder and keep the
    // difference if it did not go negative. Remainder < divisor, so the
    // 32-bit difference is exact whenever it is kept.
    assign rem_sh   = {hi_q, lo_q[31]};
    assign ge       = rem_sh >= {1'b0, opb_q};
    assign div_hi_n = ge ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];
    assign div_lo_n = {lo_q[30:0], ge};

    // Upper word of the negated 64-bit product: ~hi plus the carry out of ~lo+1.
    assign neg_hi   = ~mul_hi_n + {31'h0, (mul_lo_n == 32'h0)};

    always_comb begin
        iter_res = 32'h0;
        if (state_q == S_MUL) begin
            if (op_q == 2'b00) iter_res = mul_lo_n;
            else               iter_res = neg_q ? neg_hi : mul_hi_n;
        end else begin
            if (op_q[1]) iter_res = neg_q ? -div_hi_n : div_hi_n;
            else         iter_res = neg_q ? -div_lo_n : div_lo_n;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op_i[2]) state_d = special ? S_DONE : S_DIV;
`ifdef MDU_FAST_MUL_EN
                    else             state_d = S_DONE;
`else
                    else             state_d = S_MUL;
`endif
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush_i)           state_d = S_IDLE;
                else if (cnt_q == 5'd31)   state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            opb_q    <= 32'h0;
            cnt_q    <= 5'd0;
            rd_q     <= 5'd0;
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            result_q <= 32'h0;
            rd_out_q <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q <= 5'd0;
                        rd_q  <= bus.rd_addr_i;
                        op_q  <= bus.op_i[1:0];
                        hi_q  <= 32'h0;
                        // Remainder follows the dividend; everything else XORs.
                        neg_q <= (bus.op_i[2] && bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
                        if (bus.op_i[2]) begin
                            lo_q  <= a_mag;
                            opb_q <= b_mag;
                            if (special) begin
                                result_q <= special_res;
                                rd_out_q <= bus.rd_addr_i;
                            end
                        end else begin
                            lo_q  <= b_mag;
                            opb_q <= a_mag;
`ifdef MDU_FAST_MUL_EN
                            result_q <= fast_res;
                            rd_out_q <= bus.rd_addr_i;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (!bus.flush_i) begin
                        hi_q  <= (state_q == S_MUL) ? mul_hi_n : div_hi_n;
                        lo_q  <= (state_q == S_MUL) ? mul_lo_n : div_lo_n;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            result_q <= iter_res;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o    = (state_q != S_IDLE);
    assign bus.valid_o   = (state_q == S_DONE);
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_out_q;
endmodule

// File: tb/tb_mdu_riscv.sv
// tb_mdu_riscv -- directed self-checking bench for mdu_riscv.
module tb_mdu_riscv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    mdu_if bus ();

    mdu_riscv u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from a point just after a rising edge; wait for valid_o and
    // check latency, result and destination, then the return to idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat);
        int n;
        bus.start_i   = 1'b1;
        bus.op_i      = op;
        bus.rs1_i     = a;
        bus.rs2_i     = b;
        bus.rd_addr_i = rd;
        step();
        bus.start_i = 1'b0;
        n = 1;
        while (!bus.valid_o && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_res"}, bus.result_o, exp);
        chk({tag, "_rd"}, 32'(bus.rd_addr_o), 32'(rd));
        step();
        chk({tag, "_idle"}, 32'({bus.busy_o, bus.valid_o}), 32'd0);
    endtask

    initial begin
        int vcnt;
        bus.start_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.op_i      = 3'b000;
        bus.rs1_i     = 32'h0;
        bus.rs2_i     = 32'h0;
        bus.rd_addr_i = 5'd0;
        step();
        step();
        chk("rst_busy",   32'(bus.busy_o), 32'd0);
        chk("rst_valid",  32'(bus.valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'h0);
        chk("rst_rd",     32'(bus.rd_addr_o), 32'd0);
        rst = 1'b0;
        step();

        run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, MUL_LAT);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, MUL_LAT);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, 33);
        run_op("divu",   3'b101, 32'h0000_0007, 32'h0000_0002, 5'd10, 32'h0000_0003, 33);
        run_op("remu",   3'b111, 32'h0000_0007, 32'h0000_0002, 5'd0,  32'h0000_0001, 33);
        run_op("div0",   3'b100, 32'h0000_0005, 32'h0000_0000, 5'd11, 32'hFFFF_FFFF, 1);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1);
        run_op("remu0",  3'b111, 32'h0000_0005, 32'h0000_0000, 5'd7,  32'h0000_0005, 1);

        // Flush ten cycles into a long op (a divide when multiplies are single-cycle).
        bus.start_i   = 1'b1;
`ifdef MDU_FAST_MUL_EN
        bus.op_i      = 3'b101;
`else
        bus.op_i      = 3'b000;
`endif
        bus.rs1_i     = 32'h0000_0003;
        bus.rs2_i     = 32'h0000_0004;
        bus.rd_addr_i = 5'd20;
        step();
        bus.start_i = 1'b0;
        vcnt = 0;
        repeat (10) begin
            if (bus.valid_o) vcnt++;
            step();
        end
        chk("flush_busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush_busy_after", 32'(bus.busy_o), 32'd0);
        chk("flush_result",     bus.result_o, 32'h0000_0005);
        chk("flush_rd",         32'(bus.rd_addr_o), 32'd7);
        repeat (40) begin
            if (bus.valid_o) vcnt++;
            step();
        end
        chk("flush_no_valid", 32'(vcnt), 32'd0);

        // Start held off while busy, including in the DONE cycle.
        bus.start_i   = 1'b1;
        bus.op_i      = 3'b101;
        bus.rs1_i     = 32'h0000_0007;
        bus.rs2_i     = 32'h0000_0002;
        bus.rd_addr_i = 5'd21;
        step();
        bus.start_i = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 5) begin
                bus.start_i = 1'b1;
                bus.op_i    = 3'b000;
                bus.rs1_i   = 32'h0000_0009;
            end else if (i == 6) begin
                bus.start_i = 1'b0;
            end
            if (bus.valid_o) begin
                vcnt++;
                if (vcnt == 1) begin
                    chk("ovl_res", bus.result_o, 32'h0000_0003);
                    chk("ovl_rd",  32'(bus.rd_addr_o), 32'd21);
                    bus.start_i = 1'b1;
                    step();
                    bus.start_i = 1'b0;
                    chk("ovl_done_start_ignored", 32'(bus.busy_o), 32'd0);
                    continue;
                end
            end
            step();
        end
        chk("ovl_one_valid", 32'(vcnt), 32'd1);

        // Reset in the middle of a divide.
        bus.start_i   = 1'b1;
        bus.op_i      = 3'b100;
        bus.rs1_i     = 32'd100;
        bus.rs2_i     = 32'd7;
        bus.rd_addr_i = 5'd4;
        step();
        bus.start_i = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        chk("mrst_busy",   32'(bus.busy_o), 32'd0);
        chk("mrst_valid",  32'(bus.valid_o), 32'd0);
        chk("mrst_result", bus.result_o, 32'h0);
        chk("mrst_rd",     32'(bus.rd_addr_o), 32'd0);
        rst = 1'b0;
        step();
        run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mdu_riscv.md
# mdu_riscv

Iterative RV32M multiply/divide unit sitting between the register file read ports and the register file write port. It takes two operand words from the register file read ports (`read_data1_o`/`read_data2_o`), performs one of the eight M-extension operations over multiple cycles, and returns a result word plus destination index for the register file write port. The pipeline holds while `busy_o` is high.

## Interface
Parameters:
- none; datapath fixed at 32 bits, iteration count fixed at 32.

Ports:
- `clk_i` in 1: single clock, all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: request; accepted only at an edge where `busy_o`=0 and `flush_i`=0.
- `op_i` in 3: funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rd_addr_i` in 5: destination register, captured with operands.
- `rs1_i` in 32: operand A, dividend or multiplicand, from `read_data1_o`.
- `rs2_i` in 32: operand B, divisor or multiplier, from `read_data2_o`.
- `flush_i` in 1: abort the in-flight operation.
- `busy_o` out 1: high in states MUL, DIV and DONE.
- `valid_o` out 1: high exactly one cycle, while in DONE.
- `rd_addr_o` out 5: captured `rd_addr_i`; drives `write_addr_i` of the register file.
- `result_o` out 32: registered result; drives `write_data_i` of the register file.

## Operation
- The FSM has four states:
  - IDLE: `start_i` with `op_i[2]`=0 goes to MUL. `start_i` with `op_i[2]`=1 goes to DIV, or straight to DONE on a special case.
  - MUL and DIV: iterate; go to DONE after 32 iterations.
  - DONE: return to IDLE unconditionally.
- Sign handling:
  - Operands are converted to magnitudes per op. MULH treats A and B as signed. MULHSU treats A as signed and B as unsigned. DIV and REM are signed. Unsigned ops are unchanged.
  - The result sign is recorded at capture.
- Multiply: radix-2 shift-add into a 64-bit product.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32] after two's-complement negation of the full 64-bit product when the result sign is negative.
- Divide: restoring, one quotient bit per cycle, on 32-bit magnitudes.
  - Quotient is negated if the operand signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Special cases are resolved at capture, with no iteration:
  - Divide by zero: DIV and DIVU return 0xFFFFFFFF. REM and REMU return the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV): returns 0x80000000. The same operands under REM return 0.
- `rd_addr_i`=0 is processed normally; the register file discards the write.
- `start_i` while `busy_o`=1 (including the DONE cycle) is ignored; it is neither queued nor acknowledged.
- `flush_i` while busy: next edge goes to IDLE, no `valid_o`, `result_o` and `rd_addr_o` unchanged.
- `flush_i` together with `start_i` in IDLE: flush wins and the start is dropped.
- `rst_i` overrides everything at the next edge, including mid-operation.
  - Reset values: state IDLE, `busy_o`=0, `valid_o`=0, `result_o`=0, `rd_addr_o`=0, iteration counter 0.

## Timing
- Start accepted at edge k. Iterations run on edges k+1..k+32.
- Edge k+32 loads `result_o` (sign correction applied) and enters DONE.
- `valid_o`=1 in the cycle after edge k+32. Edge k+33 returns to IDLE, `busy_o`=0.
- Iterative latency: 33 cycles from `start_i` to `valid_o`. Minimum start-to-start spacing: 34 cycles.
- Special-case divides: DONE at edge k, `valid_o` in the next cycle, 1-cycle latency.
- `result_o` and `rd_addr_o` hold their last value until the next DONE.

## Configuration
- `MDU_FAST_MUL_EN` defined: multiplies use a single-cycle 33x33 signed combinational multiply, go from IDLE straight to DONE, and have 1-cycle latency.
- `MDU_FAST_MUL_EN` undefined: multiplies use the 32-cycle iterative path.
- Divide behaviour, special cases, flush and reset are identical in both builds.

## Test plan
- MUL, A=0x00000007, B=0xFFFFFFFD, rd=5 -> `valid_o` 33 cycles later (1 with `MDU_FAST_MUL_EN`), `result_o`=0xFFFFFFEB, `rd_addr_o`=5.
- High multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 7/2 -> 3; REMU 7/2 -> 1.
  - Each iterative divide has 33-cycle latency.
- Special cases, each with `valid_o` one cycle after start:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Flush and overlapping start:
  - Assert `flush_i` 10 cycles into a MUL -> no `valid_o`; `busy_o`=0 after the next edge; `result_o` keeps its previous value.
  - `start_i` pulsed during busy -> ignored, only one `valid_o`.
- `rst_i` asserted mid-DIV -> next edge all outputs 0, state IDLE; a fresh DIVU 100/7 then returns 14.
